// File: rtl/iob_cache_be_mem_pkg.sv
// Shared types and constants for the cache back-end memory model:
// FSM state encoding and the wait-counter width.
package iob_cache_be_mem_pkg;

  localparam int LAT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [LAT_W-1:0] lat_init(input int latency);
    return LAT_W'(latency);
  endfunction

endpackage

// File: rtl/iob_cache_be_mem_model_if.sv
// Cache back-end request/response bundle. Handshake: the master holds req with
// addr/wdata/wstrb (wstrb all-zero = read); the slave answers with a one-cycle ack.
interface iob_cache_be_mem_model_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
) ();

  logic                  req;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic [DATA_W-1:0]     rdata;
  logic                  ack;

  modport master (output req, addr, wdata, wstrb, input rdata, ack);
  modport slave  (input req, addr, wdata, wstrb, output rdata, ack);

endinterface

// File: rtl/iob_ram_sp_be.sv
// Single-port RAM with per-byte write enables, synchronous write and
// combinational read. Contents are never reset.
module iob_ram_sp_be #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                en,
  input  logic [DATA_W/8-1:0] we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    for (int b = 0; b < DATA_W/8; b++) begin
      if (en && we[b]) begin
        mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/iob_cache_be_mem_model.sv
// Latency-configurable memory model for a cache back-end (IDLE/WAIT/RESP FSM).
// Optional completion counters are built when IOB_CACHE_BE_MEM_STATS_EN is defined.
module iob_cache_be_mem_model
  import iob_cache_be_mem_pkg::*;
#(
  parameter int BE_ADDR_W  = 24,
  parameter int BE_DATA_W  = 32,
  parameter int MEM_ADDR_W = 10,
  parameter int LATENCY    = 3
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  iob_cache_be_mem_model_if.slave     be,
  output logic                        busy_o,
  output logic [31:0]                 rd_cnt_o,
  output logic [31:0]                 wr_cnt_o
);

  localparam int BE_NBYTES = BE_DATA_W / 8;
  localparam int OFF_W     = $clog2(BE_NBYTES);

  state_t                 state_q, state_d;
  logic [LAT_W-1:0]       cnt_q, cnt_d;
  logic                   accept;
  logic [BE_ADDR_W-1:0]   addr_full;
  logic [MEM_ADDR_W-1:0]  word_q;
  logic [BE_DATA_W-1:0]   wdata_q, rdata_q, ram_rdata;
  logic [BE_NBYTES-1:0]   wstrb_q;
  logic                   resp, is_read, unused_addr;

  assign addr_full   = be.addr;
  assign unused_addr = ^addr_full;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE, RESP: begin
        if (be.req) begin
          accept  = 1'b1;
          cnt_d   = lat_init(LATENCY);
          state_d = (LATENCY == 0) ? RESP : WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        // Requests seen here are dropped; only the counter advances.
        if (cnt_q == LAT_W'(1)) state_d = RESP;
        else                    cnt_d   = cnt_q - LAT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (resp && is_read) rdata_q <= ram_rdata;
      if (accept) begin
        word_q  <= addr_full[OFF_W +: MEM_ADDR_W];
        wdata_q <= be.wdata;
        wstrb_q <= be.wstrb;
      end
    end
  end

  assign resp    = (state_q == RESP);
  assign is_read = (wstrb_q == '0);

  // Write commits on the edge that closes RESP, so a read accepted on that
  // same edge sees the new word during its own RESP cycle.
  iob_ram_sp_be #(
    .DATA_W (BE_DATA_W),
    .ADDR_W (MEM_ADDR_W)
  ) u_ram (
    .clk   (clk_i),
    .en    (resp && !is_read),
    .we    (wstrb_q),
    .addr  (word_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  assign be.rdata = (resp && is_read) ? ram_rdata : rdata_q;
  assign be.ack   = resp;
  assign busy_o   = (state_q != IDLE);

`ifdef IOB_CACHE_BE_MEM_STATS_EN
  logic [31:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (resp) begin
      if (is_read && rd_cnt_q != 32'hFFFF_FFFF)  rd_cnt_q <= rd_cnt_q + 32'd1;
      if (!is_read && wr_cnt_q != 32'hFFFF_FFFF) wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  assign rd_cnt_o = rd_cnt_q;
  assign wr_cnt_o = wr_cnt_q;
`else
  assign rd_cnt_o = '0;
  assign wr_cnt_o = '0;
`endif

endmodule

// File: tb/tb_iob_cache_be_mem_model.sv
// Bench for iob_cache_be_mem_model: one instance at LATENCY=3, one at LATENCY=0,
// checked against a word-array memory model with byte-lane merging.
module tb_iob_cache_be_mem_model;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy3, busy0;
  logic [31:0] rd_cnt3, wr_cnt3, rd_cnt0, wr_cnt0;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m3 [int];
  logic [31:0] m0 [int];
  logic [31:0] last_rd3;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  iob_cache_be_mem_model_if #(.ADDR_W(24), .DATA_W(32)) bi3 ();
  iob_cache_be_mem_model_if #(.ADDR_W(24), .DATA_W(32)) bi0 ();

  iob_cache_be_mem_model #(.LATENCY(3)) dut3 (
    .clk_i(clk), .rst_n_i(rst_n), .be(bi3.slave),
    .busy_o(busy3), .rd_cnt_o(rd_cnt3), .wr_cnt_o(wr_cnt3)
  );

  iob_cache_be_mem_model #(.LATENCY(0)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .be(bi0.slave),
    .busy_o(busy0), .rd_cnt_o(rd_cnt0), .wr_cnt_o(wr_cnt0)
  );

  function automatic int word_of(input logic [23:0] a);
    return int'((a >> 2) & 24'd1023);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [23:0] alias_addr(input int word);
    logic [11:0] up;
    logic [1:0]  lo;
    up = 12'($urandom_range(0, 4095));
    lo = 2'($urandom_range(0, 3));
    return {up, 10'(word), lo};
  endfunction

  // Starts at a negedge; issues one request on dut3 and returns at the
  // negedge of the ack cycle (lat = samples until ack, -1 on timeout).
  task automatic txn3(input logic [23:0] a, input logic [31:0] d, input logic [3:0] s,
                      output int lat, output logic [31:0] rd);
    int i;
    bi3.req = 1'b1; bi3.addr = a; bi3.wdata = d; bi3.wstrb = s;
    @(negedge clk);
    bi3.req = 1'b0;
    i = 1;
    while (!bi3.ack && i < 40) begin
      @(negedge clk);
      i++;
    end
    lat = bi3.ack ? i : -1;
    rd  = bi3.rdata;
  endtask

  task automatic test_reset();
    if (bi3.ack !== 1'b0) begin miscompares++; $display("FAIL reset_ack3 got %b want 0", bi3.ack); end
    vectors++;
    if (busy3 !== 1'b0) begin miscompares++; $display("FAIL reset_busy3 got %b want 0", busy3); end
    vectors++;
    if (bi3.rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata3 got %h want 0", bi3.rdata); end
    vectors++;
    if ({rd_cnt3, wr_cnt3} !== 64'h0) begin miscompares++; $display("FAIL reset_cnt3 got %h/%h want 0/0", rd_cnt3, wr_cnt3); end
    vectors++;
    if ({bi0.ack, busy0} !== 2'b00) begin miscompares++; $display("FAIL reset_ack_busy0 got %b%b want 00", bi0.ack, busy0); end
    vectors++;
    if (bi0.rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata0 got %h want 0", bi0.rdata); end
    vectors++;
  endtask

  task automatic test_basic();
    int lat;
    logic [31:0] rd;
    txn3(24'h000010, 32'hDEADBEEF, 4'hF, lat, rd);
    m3[word_of(24'h10)] = 32'hDEADBEEF;
    if (lat !== 4) begin miscompares++; $display("FAIL basic_wr_lat got %0d want 4", lat); end
    vectors++;
    txn3(24'h000010, 32'h0, 4'h0, lat, rd);
    if (lat !== 4) begin miscompares++; $display("FAIL basic_rd_lat got %0d want 4", lat); end
    vectors++;
    if (rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL basic_rd_data got %h want deadbeef", rd); end
    vectors++;
    last_rd3 = 32'hDEADBEEF;
  endtask

  task automatic test_partial();
    int lat;
    logic [31:0] rd, exp;
    txn3(24'h000010, 32'h0000AA00, 4'h2, lat, rd);
    m3[word_of(24'h10)] = merge(m3[word_of(24'h10)], 32'h0000AA00, 4'h2);
    if (rd !== last_rd3) begin miscompares++; $display("FAIL partial_wr_keeps_rdata got %h want %h", rd, last_rd3); end
    vectors++;
    txn3(24'h000010, 32'h0, 4'h0, lat, rd);
    exp = m3[word_of(24'h10)];
    if (rd !== exp || exp !== 32'hDEADAAEF) begin miscompares++; $display("FAIL partial_rd got %h want deadaaef", rd); end
    vectors++;
    last_rd3 = exp;
  endtask

  task automatic test_wait_ignore();
    logic [4:0] busy_seen;
    int acks;
    int lat;
    logic [31:0] rd;
    m3[20] = 32'h12345678;
    txn3(alias_addr(20), 32'h12345678, 4'hF, lat, rd);
    bi3.req = 1'b1; bi3.addr = alias_addr(4); bi3.wdata = 32'h0; bi3.wstrb = 4'h0;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      busy_seen[4-i] = busy3;
      if (bi3.ack) acks++;
      if (i == 0) begin
        bi3.req = 1'b1; bi3.addr = 24'h000050; bi3.wdata = 32'hBAD0BAD0; bi3.wstrb = 4'hF;
      end else begin
        bi3.req = 1'b0;
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bi3.ack) acks++;
    end
    if (busy_seen !== 5'b11110) begin miscompares++; $display("FAIL wait_busy_pattern got %b want 11110", busy_seen); end
    vectors++;
    if (acks !== 1) begin miscompares++; $display("FAIL wait_ack_count got %0d want 1", acks); end
    vectors++;
    txn3(alias_addr(20), 32'h0, 4'h0, lat, rd);
    if (rd !== m3[20]) begin miscompares++; $display("FAIL wait_ignored_write got %h want %h", rd, m3[20]); end
    vectors++;
    last_rd3 = rd;
  endtask

  task automatic test_random_l3();
    int lat, w;
    logic [31:0] rd, d, exp;
    logic [3:0] s;
    for (int k = 0; k < 8; k++) begin
      d = $urandom;
      m3[k] = d;
      txn3(alias_addr(k), d, 4'hF, lat, rd);
    end
    for (int k = 0; k < 24; k++) begin
      w = $urandom_range(0, 7);
      d = $urandom;
      s = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
      if (s == 4'h0) exp_q.push_back(m3[w]);
      else m3[w] = merge(m3[w], d, s);
      txn3(alias_addr(w), d, s, lat, rd);
      if (lat !== 4) begin miscompares++; $display("FAIL rand_lat op %0d got %0d want 4", k, lat); end
      vectors++;
      if (s == 4'h0) begin
        exp = exp_q.pop_front();
        if (rd !== exp) begin miscompares++; $display("FAIL rand_rd op %0d got %h want %h", k, rd, exp); end
        last_rd3 = exp;
      end else begin
        if (rd !== last_rd3) begin miscompares++; $display("FAIL rand_wr_hold op %0d got %h want %h", k, rd, last_rd3); end
      end
      vectors++;
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] a [20];
    logic [31:0] d [20];
    logic [3:0]  s [20];
    logic [31:0] exp, last;
    int w;
    for (int k = 0; k < 4; k++) begin
      a[k] = alias_addr(k); d[k] = $urandom; s[k] = 4'hF;
    end
    for (int k = 4; k < 8; k++) begin
      a[k] = alias_addr(2); d[k] = $urandom; s[k] = (k % 2 == 0) ? 4'hF : 4'h0;
    end
    for (int k = 8; k < 20; k++) begin
      a[k] = alias_addr($urandom_range(0, 3)); d[k] = $urandom;
      s[k] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
    end
    last = 32'h0;
    for (int k = 0; k < 20; k++) begin
      bi0.req = 1'b1; bi0.addr = a[k]; bi0.wdata = d[k]; bi0.wstrb = s[k];
      w = word_of(a[k]);
      if (s[k] != 4'h0) m0[w] = merge(m0.exists(w) ? m0[w] : 32'h0, d[k], s[k]);
      exp = (s[k] == 4'h0) ? m0[w] : last;
      last = exp;
      @(negedge clk);
      if (bi0.ack !== 1'b1) begin miscompares++; $display("FAIL b2b_ack op %0d got %b want 1", k, bi0.ack); end
      vectors++;
      if (bi0.rdata !== exp) begin miscompares++; $display("FAIL b2b_rdata op %0d got %h want %h", k, bi0.rdata, exp); end
      vectors++;
    end
    bi0.req = 1'b0;
    @(negedge clk);
    if ({bi0.ack, busy0} !== 2'b00) begin miscompares++; $display("FAIL b2b_idle got %b%b want 00", bi0.ack, busy0); end
    vectors++;
  endtask

  task automatic test_reset_mid();
    int acks, lat;
    logic [31:0] rd;
    bi3.req = 1'b1; bi3.addr = 24'h000010; bi3.wdata = 32'h55667788; bi3.wstrb = 4'hF;
    @(negedge clk);
    bi3.req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    if ({bi3.ack, busy3} !== 2'b00) begin miscompares++; $display("FAIL rstmid_ack_busy got %b%b want 00", bi3.ack, busy3); end
    vectors++;
    if (bi3.rdata !== 32'h0) begin miscompares++; $display("FAIL rstmid_rdata got %h want 0", bi3.rdata); end
    vectors++;
    if ({rd_cnt3, wr_cnt3} !== 64'h0) begin miscompares++; $display("FAIL rstmid_cnt got %h/%h want 0/0", rd_cnt3, wr_cnt3); end
    vectors++;
    acks = 0;
    repeat (3) begin @(negedge clk); if (bi3.ack) acks++; end
    rst_n = 1'b1;
    repeat (6) begin @(negedge clk); if (bi3.ack) acks++; end
    if (acks !== 0) begin miscompares++; $display("FAIL rstmid_no_ack got %0d want 0", acks); end
    vectors++;
    txn3(24'h000010, 32'h0, 4'h0, lat, rd);
    if (rd !== m3[word_of(24'h10)]) begin miscompares++; $display("FAIL rstmid_mem got %h want %h", rd, m3[word_of(24'h10)]); end
    vectors++;
  endtask

  task automatic test_stats();
    int lat, n_rd, n_wr;
    logic [31:0] rd, exp_rd, exp_wr;
    n_rd = 1;
    n_wr = 0;
    for (int k = 0; k < 7; k++) begin
      if (k % 2 == 0 && n_wr < 3) begin
        txn3(alias_addr(k), $urandom, 4'hF, lat, rd);
        n_wr++;
      end else begin
        txn3(alias_addr(k), 32'h0, 4'h0, lat, rd);
        n_rd++;
      end
    end
    repeat (2) @(negedge clk);
`ifdef IOB_CACHE_BE_MEM_STATS_EN
    exp_rd = 32'(n_rd);
    exp_wr = 32'(n_wr);
`else
    exp_rd = 32'h0;
    exp_wr = 32'h0;
`endif
    if (rd_cnt3 !== exp_rd) begin miscompares++; $display("FAIL stats_rd got %0d want %0d", rd_cnt3, exp_rd); end
    vectors++;
    if (wr_cnt3 !== exp_wr) begin miscompares++; $display("FAIL stats_wr got %0d want %0d", wr_cnt3, exp_wr); end
    vectors++;
    if ({rd_cnt0, wr_cnt0} !== 64'h0) begin miscompares++; $display("FAIL stats_idle0 got %h/%h want 0/0", rd_cnt0, wr_cnt0); end
    vectors++;
  endtask

  initial begin
    bi3.req = 1'b0; bi3.addr = '0; bi3.wdata = '0; bi3.wstrb = '0;
    bi0.req = 1'b0; bi0.addr = '0; bi0.wdata = '0; bi0.wstrb = '0;
    last_rd3 = 32'h0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_basic();
    test_partial();
    test_wait_ignore();
    test_random_l3();
    test_back_to_back();
    test_reset_mid();
    test_stats();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
